mdu_hilo: RTL and testbench



---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_div_core.sv | 71 +++++++
 rtl/mdu_hilo.sv | 116 +++++++++++
 tb/tb_mdu_hilo.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide unit.
// MDU_FAST_MULT_EN (see mdu_hilo) selects a single-cycle multiplier.
package mdu_pkg;

    localparam int MDU_ITERS = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_t;

    typedef logic [0:0] mdu_state_t;
    localparam mdu_state_t ST_IDLE = 1'b0;
    localparam mdu_state_t ST_RUN  = 1'b1;

    // Sign bookkeeping captured when an iterative op is accepted.
    typedef struct packed {
        logic        is_div;
        logic        neg;
        logic        rem_neg;
        logic        div0;
        logic [31:0] a;
    } mdu_ctx_t;

    function automatic logic [31:0] cneg32(input logic [31:0] x, input logic n);
        return n ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] x, input logic n);
        return n ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned iterative datapath: restoring divide or shift-add multiply,
// one bit per enabled cycle. acc_nxt is the result of the current step.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int ITERS = MDU_ITERS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        load,
    input  logic        run,
    input  logic        is_div,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [63:0] acc_nxt,
    output logic        last
);
    localparam int CW = $clog2(ITERS + 1);

    logic [63:0]   acc_q, acc_d;
    logic [31:0]   opnd_q, opnd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_div_q, is_div_d;
    logic [32:0]   shifted;
    logic [33:0]   diff;
    logic [32:0]   sum;

    // Divide: acc = {remainder, dividend/quotient}. Multiply: acc = {high, multiplier/low}.
    always_comb begin
        shifted = acc_q[63:31];
        diff    = {1'b0, shifted} - {2'b00, opnd_q};
        sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        if (is_div_q)
            acc_nxt = diff[33] ? {shifted[31:0], acc_q[30:0], 1'b0}
                               : {diff[31:0], acc_q[30:0], 1'b1};
        else
            acc_nxt = {sum, acc_q[31:1]};

        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        if (load) begin
            acc_d    = {32'd0, is_div ? a_mag : b_mag};
            opnd_d   = is_div ? b_mag : a_mag;
            cnt_d    = '0;
            is_div_d = is_div;
        end else if (run) begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign last = run && (cnt_q == CW'(ITERS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
        end else if (clk_enable) begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// HI/LO owner: MULT/MULTU/DIV/DIVU/MTHI/MTLO with a busy interlock.
// Define MDU_FAST_MULT_EN for single-edge multiplies; otherwise they iterate.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int ITERS = MDU_ITERS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  mdu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    mdu_state_t  state_q, state_d;
    mdu_ctx_t    ctx_q, ctx_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        accept, is_signed, is_div_op, is_mul_op, iter_op;
    logic [31:0] a_mag, b_mag;
    logic [63:0] acc_nxt;
    logic        last;

    assign busy      = (state_q == ST_RUN);
    assign accept    = start && !busy && clk_enable;
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign a_mag     = cneg32(a, is_signed && a[31]);
    assign b_mag     = cneg32(b, is_signed && b[31]);

`ifdef MDU_FAST_MULT_EN
    logic [63:0] fprod;
    assign fprod   = 64'(a_mag) * 64'(b_mag);
    assign iter_op = is_div_op;
`else
    assign iter_op = is_div_op || is_mul_op;
`endif

    mdu_div_core #(.ITERS(ITERS)) u_core (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .load       (accept && iter_op),
        .run        (busy),
        .is_div     (is_div_op),
        .a_mag      (a_mag),
        .b_mag      (b_mag),
        .acc_nxt    (acc_nxt),
        .last       (last)
    );

    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (accept) begin
            case (op)
                OP_MTHI: hi_d = a;
                OP_MTLO: lo_d = a;
                default: begin
                    if (iter_op) begin
                        state_d       = ST_RUN;
                        ctx_d.is_div  = is_div_op;
                        ctx_d.neg     = is_signed && (a[31] ^ b[31]);
                        ctx_d.rem_neg = is_signed && a[31];
                        ctx_d.div0    = (b == 32'd0);
                        ctx_d.a       = a;
                    end
`ifdef MDU_FAST_MULT_EN
                    else if (is_mul_op)
                        {hi_d, lo_d} = cneg64(fprod, is_signed && (a[31] ^ b[31]));
`endif
                end
            endcase
        end

        // Both halves commit together on the final step; nothing leaks mid-run.
        if (last) begin
            state_d = ST_IDLE;
            if (!ctx_q.is_div) begin
                {hi_d, lo_d} = cneg64(acc_nxt, ctx_q.neg);
            end else if (ctx_q.div0) begin
                hi_d = ctx_q.a;
                lo_d = 32'hFFFF_FFFF;
            end else begin
                hi_d = cneg32(acc_nxt[63:32], ctx_q.rem_neg);
                lo_d = cneg32(acc_nxt[31:0], ctx_q.neg);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ctx_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (clk_enable) begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: the driver queues expected HI/LO and completion
// cycle; the monitor pops whenever busy falls or HI/LO change.
module tb_mdu_hilo;
    import mdu_pkg::*;

`ifdef MDU_FAST_MULT_EN
    localparam int MLAT = 0;
`else
    localparam int MLAT = MDU_ITERS;
`endif

    logic        clk = 1'b0, reset = 1'b1, clk_enable = 1'b1, start = 1'b0;
    mdu_op_t     op = OP_MTLO;
    logic [31:0] a = '0, b = '0;
    logic        busy;
    logic [31:0] hi, lo;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t q[$];
    int   checks = 0, passed = 0, cyc = 0;

    mdu_hilo dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
        .op(op), .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor
    logic        pb;
    logic [31:0] ph, pl;
    exp_t        e;
    always @(negedge clk) begin
        if (reset) begin
            pb = busy; ph = hi; pl = lo;
        end else begin
            if ((pb && !busy) || hi !== ph || lo !== pl) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: hi=%h lo=%h busy=%b, none expected", hi, lo, busy);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                    if (e.due >= 0) chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
                end
            end
            pb = busy; ph = hi; pl = lo;
        end
    end

    task automatic push_exp(input string nm, input logic [31:0] eh, input logic [31:0] el, input int due);
        exp_t t;
        t.name = nm; t.hi = eh; t.lo = el; t.due = due;
        q.push_back(t);
    endtask

    task automatic issue(input mdu_op_t o, input logic [31:0] ia, input logic [31:0] ib,
                         input string nm, input logic [31:0] eh, input logic [31:0] el,
                         input int lat, input bit push);
        @(negedge clk);
        start = 1'b1; op = o; a = ia; b = ib;
        if (push) push_exp(nm, eh, el, cyc + 1 + lat);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = OP_MULT;
        chk({nm, "_busy_after_accept"}, {31'd0, busy}, 32'(lat > 0));
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d results outstanding, 0 required", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b0;

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001, MLAT, 1);
        drain();
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, MLAT, 1);
        drain();
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, 1);
        drain();

        // Divide by zero; an MTLO held from cycle 5 until busy drops must be ignored.
        issue(OP_DIVU, 32'd7, 32'd0, "divu_by0", 32'd7, 32'hFFFF_FFFF, 32, 1);
        for (int k = 2; k <= 60 && busy; k++) begin
            @(negedge clk);
            if (k == 5) begin start = 1'b1; op = OP_MTLO; a = 32'h1234; end
        end
        start = 1'b0;
        drain();

        issue(OP_DIVU, 32'd100, 32'd7, "divu_stall", 32'd2, 32'd14, 37, 1);
        repeat (8) @(negedge clk);
        clk_enable = 1'b0;
        repeat (5) @(negedge clk);
        clk_enable = 1'b1;
        drain();

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32'd0, 32'h8000_0000, 32, 1);
        drain();
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, "div_7_neg2", 32'd1, 32'hFFFF_FFFD, 32, 1);
        drain();
        issue(OP_MTLO, 32'h0BAD_F00D, 32'd0, "mtlo", 32'd1, 32'h0BAD_F00D, 0, 1);
        drain();
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0, "mthi", 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 1);
        drain();

        // Abort a divide with an asynchronous reset between edges.
        issue(OP_DIV, 32'd100, 32'd3, "div_abort", 32'd0, 32'd0, 32, 0);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        push_exp("reset_abort", 32'd0, 32'd0, -1);
        #1;
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_hi", hi, 32'd0);
        chk("async_reset_lo", lo, 32'd0);
        #1 reset = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        issue(OP_DIVU, 32'd1000, 32'd10, "divu_after_reset", 32'd0, 32'd100, 32, 1);
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, finish required");
        $fatal(1);
    end

endmodule
